// File: rtl/fetch_align_buffer_pkg.sv
// Shared types, masks and helpers for the instruction fetch/align buffer.
package fetch_align_buffer_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_e;

    localparam logic [31:0] INSN_ALIGN_MASK = 32'hFFFF_FFFE;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Stale responses can pile up across back-to-back redirects, so the drop counter is wider than DEPTH needs.
    localparam int DROP_W = 8;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_fifo.sv
// Word FIFO holding fetched instruction words; exposes the head entry and the one behind it.
module fetch_align_buffer_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [31:0]                push_data,
    input  logic                       pop,
    output logic [31:0]                head,
    output logic [31:0]                next,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
    assign next = mem[bump(rd_ptr)];

endmodule

// File: rtl/fetch_align_buffer.sv
// Instruction fetch and alignment buffer between the instruction bus and decode.
// Define LOOPYV_RVC_EN to enable 16-bit compressed instruction realignment.
module fetch_align_buffer
    import fetch_align_buffer_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        insn_valid_o,
    input  logic        insn_ready_i,
    output logic [31:0] insn_o,
    output logic [31:0] insn_pc_o,
    output logic        insn_compressed_o,
    output logic        insn_fault_o
);
    localparam int            CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [31:0]       fetch_addr_q;
    logic [31:0]       pc_q;
    logic [CW-1:0]     outstanding_q;
    logic [DROP_W-1:0] drop_q;
    logic              fault_pending_q;

    logic [CW-1:0]     count;
    logic [31:0]       head_word;
    logic [31:0]       next_word;
    logic              gnt_acc;
    logic              resp_keep;
    logic              fire;
    logic              misaligned;
    logic              avail;
    logic              is_comp;
    logic              pop_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              unused_next;

    assign gnt_acc   = instr_req_o && instr_gnt_i;
    assign resp_keep = instr_rvalid_i && (drop_q == '0);
    assign fire      = insn_valid_o && insn_ready_i;
    assign fifo_push = resp_keep && !redirect_i;
    assign fifo_pop  = fire && (state_q == FETCH_RUN) && pop_head && !redirect_i;

    fetch_align_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .push     (fifo_push),
        .push_data(instr_rdata_i),
        .pop      (fifo_pop),
        .head     (head_word),
        .next     (next_word),
        .count    (count)
    );

    assign unused_next = ^next_word;

`ifdef LOOPYV_RVC_EN
    logic h_q;

    assign misaligned = 1'b0;

    // Halfword offset into the head word; a 16-bit instruction flips it, a 32-bit one keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= 1'b0;
        end else if (redirect_i) begin
            h_q <= redirect_pc_i[1];
        end else if (fire && state_q == FETCH_RUN) begin
            h_q <= h_q ^ is_comp;
        end
    end
`else
    assign misaligned = redirect_pc_i[1];
`endif

    always_comb begin
        insn_o   = head_word;
        is_comp  = 1'b0;
        pop_head = 1'b1;
        avail    = (count != '0);
`ifdef LOOPYV_RVC_EN
        if (!h_q) begin
            if (is_compressed(head_word[15:0])) begin
                insn_o   = {16'h0000, head_word[15:0]};
                is_comp  = 1'b1;
                pop_head = 1'b0;
            end
        end else if (is_compressed(head_word[31:16])) begin
            insn_o  = {16'h0000, head_word[31:16]};
            is_comp = 1'b1;
        end else begin
            // Straddling instruction needs the low half of the following word.
            insn_o = {next_word[15:0], head_word[31:16]};
            avail  = (count >= CW'(2));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (state_q)
            FETCH_BOOT:  state_d = FETCH_RUN;
            FETCH_RUN:   state_d = FETCH_RUN;
            FETCH_FAULT: state_d = FETCH_FAULT;
            default:     state_d = FETCH_BOOT;
        endcase
        if (redirect_i) begin
            state_d = misaligned ? FETCH_FAULT : FETCH_RUN;
        end
    end

    always_comb begin
        instr_req_o  = 1'b0;
        insn_valid_o = 1'b0;
        insn_fault_o = 1'b0;
        case (state_q)
            FETCH_RUN: begin
                instr_req_o  = ({1'b0, count} + {1'b0, outstanding_q}) < LIMIT;
                insn_valid_o = avail;
            end
            FETCH_FAULT: begin
                insn_valid_o = fault_pending_q;
                insn_fault_o = fault_pending_q;
            end
            default: ;
        endcase
    end

    assign instr_addr_o      = fetch_addr_q;
    assign insn_pc_o         = pc_q;
    assign insn_compressed_o = is_comp;

    // Redirect outranks grant, response and handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr_q    <= BOOT_ADDR;
            pc_q            <= BOOT_ADDR;
            outstanding_q   <= '0;
            drop_q          <= '0;
            fault_pending_q <= 1'b0;
        end else if (redirect_i) begin
            // Everything in flight, including a grant taken now, becomes stale; a response arriving now is one of them.
            drop_q          <= drop_q + DROP_W'(outstanding_q) + DROP_W'(gnt_acc) - DROP_W'(instr_rvalid_i);
            outstanding_q   <= '0;
            fetch_addr_q    <= redirect_pc_i & WORD_ALIGN_MASK;
            pc_q            <= redirect_pc_i & INSN_ALIGN_MASK;
            fault_pending_q <= misaligned;
        end else begin
            if (gnt_acc) fetch_addr_q <= fetch_addr_q + 32'd4;
            if (instr_rvalid_i && !resp_keep) drop_q <= drop_q - DROP_W'(1);
            outstanding_q <= outstanding_q + CW'(gnt_acc) - CW'(resp_keep);
            if (fire && state_q == FETCH_RUN) pc_q <= pc_q + (is_comp ? 32'd2 : 32'd4);
            if (fire && state_q == FETCH_FAULT) fault_pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Randomised bench for fetch_align_buffer, checked against a PC / byte-stream reference model of memory.
module tb_fetch_align_buffer;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam int          DEPTH = 2;
    localparam int          NCYC  = 3000;
`ifdef LOOPYV_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt = 1'b0;
    logic        instr_rvalid = 1'b0;
    logic [31:0] instr_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_compressed;
    logic        insn_fault;

    always #5 clk = ~clk;

    fetch_align_buffer #(
        .BOOT_ADDR(BOOT),
        .DEPTH    (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_req_o      (instr_req),
        .instr_addr_o     (instr_addr),
        .instr_gnt_i      (instr_gnt),
        .instr_rvalid_i   (instr_rvalid),
        .instr_rdata_i    (instr_rdata),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .insn_valid_o     (insn_valid),
        .insn_ready_i     (insn_ready),
        .insn_o           (insn),
        .insn_pc_o        (insn_pc),
        .insn_compressed_o(insn_compressed),
        .insn_fault_o     (insn_fault)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       rq[$];
    int          stale_left = 0;
    logic [31:0] img [logic [31:0]];
    int          checks = 0;
    int          failures = 0;
    int          transfers = 0;
    int          cyc = 0;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_recv;
    bit          m_fault;
    bit          m_fault_pend;
    bit          exp_req;
    bit          exp_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        if (img.exists(a)) return img[a];
        x = a * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA77;
        return x ^ (x >> 13);
    endfunction

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a & ~32'h3);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic int exp_len(input logic [31:0] pc);
        logic [15:0] lo;
        lo = half(pc);
        return (RVC && lo[1:0] != 2'b11) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_insn(input logic [31:0] pc);
        logic [15:0] lo;
        logic [15:0] hi;
        if (!RVC) return mem_word(pc);
        lo = half(pc);
        hi = half(pc + 32'd2);
        if (lo[1:0] != 2'b11) return {16'h0000, lo};
        return {hi, lo};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic checkCycle();
        int entries;
        int avail;
        int len;
        len     = exp_len(m_pc);
        entries = int'((m_recv - (m_pc & ~32'h3)) >> 2);
        avail   = int'($signed(m_recv - m_pc));
        if (m_fault) begin
            exp_req   = 1'b0;
            exp_valid = m_fault_pend;
        end else begin
            exp_req   = (entries + rq.size() - stale_left) < DEPTH;
            exp_valid = avail >= len;
        end
        checkOutput("req", 32'(instr_req), 32'(exp_req));
        if (instr_req && exp_req) checkOutput("addr", instr_addr, m_fetch);
        checkOutput("valid", 32'(insn_valid), 32'(exp_valid));
        if (insn_valid && exp_valid) begin
            checkOutput("pc", insn_pc, m_pc);
            checkOutput("fault", 32'(insn_fault), 32'(m_fault));
            if (!m_fault) begin
                checkOutput("insn", insn, exp_insn(m_pc));
                checkOutput("compressed", 32'(insn_compressed), 32'(len == 2));
            end
        end
    endtask

    task automatic applyStimulus();
        bit          fast;
        bit          hold;
        bit          gnt;
        bit          rv;
        bit          rdy;
        bit          redir;
        bit          fire;
        int          lat;
        logic [31:0] rpc;
        resp_t       r;
        fast = cyc < 40;
        hold = (cyc >= 40) && (cyc < 44);
        if (fast) rdy = 1'b1;
        else if (cyc >= 60 && cyc < 76) rdy = 1'b0;
        else rdy = $urandom_range(0, 9) < 7;
        gnt = instr_req && (fast || hold || $urandom_range(0, 9) < 6);
        rv  = !hold && rq.size() > 0;
        if (rv) rv = (rq[0].due <= cyc) && (fast || $urandom_range(0, 3) != 0);
        lat = fast ? 0 : int'($urandom_range(0, 3));
        redir = 1'b0;
        rpc   = $urandom;
        if (cyc == 43) begin
            redir = 1'b1;
            rpc   = 32'h0000_0100;
        end else if (cyc == 80) begin
            redir = 1'b1;
            rpc   = 32'h0000_0102;
        end else if (cyc == 86) begin
            redir = 1'b1;
            rpc   = 32'h0000_0200;
        end else if (cyc > 100 && $urandom_range(0, 29) == 0) begin
            redir = 1'b1;
            rpc   = {($urandom_range(0, 7) == 0) ? 24'hFF_FFFF : 24'h00_0000,
                     6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        end

        instr_gnt    = gnt;
        instr_rvalid = rv;
        instr_rdata  = rv ? mem_word(rq[0].addr) : $urandom;
        insn_ready   = rdy;
        redirect     = redir;
        redirect_pc  = rpc;

        fire = exp_valid && rdy;
        if (fire && !redir && !m_fault) transfers++;
        r.addr = m_fetch;
        r.due  = cyc + 1 + lat;
        if (redir) begin
            if (gnt) rq.push_back(r);
            stale_left = rq.size();
            if (rv) begin
                void'(rq.pop_front());
                stale_left--;
            end
            m_pc         = rpc & ~32'h1;
            m_fetch      = rpc & ~32'h3;
            m_recv       = m_fetch;
            m_fault      = !RVC && rpc[1];
            m_fault_pend = m_fault;
        end else begin
            if (rv) begin
                void'(rq.pop_front());
                if (stale_left > 0) stale_left--;
                else m_recv = m_recv + 32'd4;
            end
            if (gnt) begin
                rq.push_back(r);
                m_fetch = m_fetch + 32'd4;
            end
            if (fire) begin
                if (m_fault) m_fault_pend = 1'b0;
                else m_pc = m_pc + 32'(exp_len(m_pc));
            end
        end
    endtask

    initial begin
        img[32'h0000_0000] = 32'h0050_0093;
        img[32'h0000_0004] = 32'h00A0_0113;
        img[32'h0000_0008] = 32'h0001_0505;
        img[32'h0000_000C] = 32'h0093_0001;
        img[32'h0000_0010] = 32'h1234_0050;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req", 32'(instr_req), 32'd0);
        checkOutput("reset_valid", 32'(insn_valid), 32'd0);
        checkOutput("reset_fault", 32'(insn_fault), 32'd0);
        rst          = 1'b0;
        m_pc         = BOOT;
        m_fetch      = BOOT;
        m_recv       = BOOT;
        m_fault      = 1'b0;
        m_fault_pend = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            checkCycle();
            applyStimulus();
        end

        checkOutput("progress", 32'(transfers >= 100), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
